// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, reset vector and fetch FSM encoding.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, word} pairs; flush empties it and overrides push/pop.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push && !i_flush && !o_full;
    assign w_pop  = i_pop && !i_flush && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC ownership, single-outstanding imem handshake, prefetch buffering
// and redirect handling with stale-response discard.
module instruction_fetch #(
    parameter int ADDR_W  = mips_pkg::ADDR_W,
    parameter int DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_pkg::RESET_PC)
) (
    input  logic                        clk,
    input  logic                        rstPC,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic                        imem_ack,
    input  logic [mips_pkg::INSTR_W-1:0] imem_rdata,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic [mips_pkg::INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]           instr_pc,
    output logic                        instr_valid
);
    import mips_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + INSTR_W;

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] r_req_addr;
    logic [ADDR_W-1:0] w_req_addr_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_redir_pc;
    logic [EW-1:0]     w_head;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_space;
    logic              w_unused;

    assign w_unused   = ^redirect_pc[1:0];
    assign w_redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_pc_inc   = r_fetch_pc + ADDR_W'(4);

    assign w_push = (r_state == REQ) && imem_ack && !redirect && !w_full;
    assign w_pop  = !w_empty && !stall;

    // A request is only (re)issued when it is guaranteed a free slot on return
    assign w_count_nxt = redirect ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    assign w_space     = (w_count_nxt < CW'(DEPTH));

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rstPC),
        .i_push  (w_push),
        .i_din   ({r_req_addr, imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_addr_nxt = r_req_addr;
        case (r_state)
            IDLE: begin
                if (redirect) begin
                    w_state_nxt    = REQ;
                    w_fetch_pc_nxt = w_redir_pc;
                    w_req_addr_nxt = w_redir_pc;
                end else if (w_space) begin
                    w_state_nxt    = REQ;
                    w_req_addr_nxt = r_fetch_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_redir_pc;
                    if (imem_ack) w_req_addr_nxt = w_redir_pc;
                    else          w_state_nxt    = DROP;
                end else if (imem_ack) begin
                    w_fetch_pc_nxt = w_pc_inc;
                    if (w_space) w_req_addr_nxt = w_pc_inc;
                    else         w_state_nxt    = IDLE;
                end
            end
            DROP: begin
                // The memory handshake completes before the new address goes out
                if (redirect) w_fetch_pc_nxt = w_redir_pc;
                if (imem_ack) begin
                    w_state_nxt    = REQ;
                    w_req_addr_nxt = redirect ? w_redir_pc : r_fetch_pc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstPC) begin
        if (!rstPC) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
        end
    end

    assign imem_req    = (r_state != IDLE);
    assign imem_addr   = r_req_addr;
    assign instr_valid = !w_empty;
    assign instruction = instr_valid ? w_head[INSTR_W-1:0] : NOP_WORD;
    assign instr_pc    = instr_valid ? w_head[EW-1:INSTR_W] : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table plus hand-written corner sequences.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstPC;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect;
    logic [31:0] redirect_pc, instruction, instr_pc;
    logic        instr_valid;

    logic        req_w, ack_w, vld_w;
    logic [31:0] addr_w, rdata_w, instr_w, pc_w;
    logic        stall_w, redir_w;
    logic [31:0] rpc_w;

    int lat;
    int wcnt;

    // Memory model: acks after `lat` wait cycles, returns word == address
    always_ff @(posedge clk or negedge rstPC) begin
        if (!rstPC)                    wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                           wcnt <= 0;
    end
    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = imem_addr;

    assign ack_w   = req_w;
    assign rdata_w = addr_w;
    assign stall_w = 1'b0;
    assign redir_w = 1'b0;
    assign rpc_w   = 32'h0;

    instruction_fetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rstPC       (rstPC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    instruction_fetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk         (clk),
        .rstPC       (rstPC),
        .imem_req    (req_w),
        .imem_addr   (addr_w),
        .imem_ack    (ack_w),
        .imem_rdata  (rdata_w),
        .stall       (stall_w),
        .redirect    (redir_w),
        .redirect_pc (rpc_w),
        .instruction (instr_w),
        .instr_pc    (pc_w),
        .instr_valid (vld_w)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Word == address, so the expected instruction equals the expected pc
    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc);
        chk({tag, "_req"}, 32'(imem_req), 32'(req));
        if (req) chk({tag, "_addr"}, imem_addr, addr);
        chk({tag, "_vld"}, 32'(instr_valid), 32'(vld));
        chk({tag, "_pc"}, instr_pc, vld ? pc : 32'h0);
        chk({tag, "_ins"}, instruction, vld ? pc : 32'h0);
    endtask

    task automatic do_reset(input int l, input logic st);
        rstPC       = 1'b0;
        stall       = st;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        lat         = l;
        @(negedge clk);
        @(negedge clk);
        chk_out("rst", 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        rstPC = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reset with 2-cycle memory and stall high; ends at cycle 7 with words 0,4
    // buffered and the request to 8 outstanding.
    task automatic prefix();
        do_reset(2, 1'b1);
        chk_out("p0", 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk_out("p1", 1'b1, 32'h0, 1'b0, 32'h0);
        repeat (3) step();
        chk_out("p4", 1'b1, 32'h4, 1'b1, 32'h0);
        repeat (3) step();
        chk_out("p7", 1'b1, 32'h8, 1'b1, 32'h0);
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[17];
    int   acks;

    initial begin
        rstPC = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; lat = 0;

        //          stall redir rpc           req  addr          vld  pc
        tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h4};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h8};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_0202, 1'b1, 32'h10,      1'b1, 32'hC};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h200,      1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h204,      1'b1, 32'h200};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h208,      1'b1, 32'h204};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h20C,      1'b1, 32'h204};
        tbl[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h210,      1'b1, 32'h204};
        tbl[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h204};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h204};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h214,      1'b1, 32'h208};
        tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h218,      1'b1, 32'h20C};
        tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h21C,      1'b1, 32'h210};
        tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h220,      1'b1, 32'h214};

        // Zero-wait streaming, redirect coinciding with ack and pop, full-FIFO stall
        do_reset(0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            chk_out($sformatf("v%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc);
            stall       = tbl[i].stall;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            step();
        end
        redirect = 1'b0;

        // Redirect while a request is outstanding: stale word 8 must never surface
        prefix();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0; redirect_pc = 32'h0;
        chk_out("d8", 1'b1, 32'h8, 1'b0, 32'h0);
        step();
        chk_out("d9", 1'b1, 32'h8, 1'b0, 32'h0);
        step();
        chk_out("d10", 1'b1, 32'h100, 1'b0, 32'h0);
        step();
        chk_out("d11", 1'b1, 32'h100, 1'b0, 32'h0);
        step();
        chk_out("d12", 1'b1, 32'h100, 1'b0, 32'h0);
        step();
        chk_out("d13", 1'b1, 32'h104, 1'b1, 32'h100);

        // Asynchronous reset mid-request with two words buffered
        prefix();
        @(posedge clk);
        #2;
        rstPC = 1'b0;
        #1;
        chk_out("ar", 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ar_addr", imem_addr, 32'h0);
        @(negedge clk);
        rstPC = 1'b1; stall = 1'b0;
        chk_out("ar0", 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk_out("ar1", 1'b1, 32'h0, 1'b0, 32'h0);

        // Slow memory with stall held: exactly four fetches, then resume at 16
        do_reset(2, 1'b1);
        acks = 0;
        for (int c = 0; c < 25; c++) begin
            if (imem_ack) acks++;
            step();
        end
        chk("full_acks", 32'(acks), 32'd4);
        chk_out("full", 1'b0, 32'h0, 1'b1, 32'h0);
        stall = 1'b0;
        step();
        chk_out("rel1", 1'b1, 32'h10, 1'b1, 32'h4);
        step();
        chk_out("rel2", 1'b1, 32'h10, 1'b1, 32'h8);
        step();
        chk_out("rel3", 1'b1, 32'h10, 1'b1, 32'hC);
        step();
        chk_out("rel4", 1'b1, 32'h14, 1'b1, 32'h10);

        // PC wrap on the second instance (RESET_PC = FFFF_FFF8, zero-wait)
        do_reset(0, 1'b0);
        step();
        chk("wr1_addr", addr_w, 32'hFFFF_FFF8);
        step();
        chk("wr2_addr", addr_w, 32'hFFFF_FFFC);
        chk("wr2_pc", pc_w, 32'hFFFF_FFF8);
        step();
        chk("wr3_addr", addr_w, 32'h0000_0000);
        chk("wr3_pc", pc_w, 32'hFFFF_FFFC);
        step();
        chk("wr4_pc", pc_w, 32'h0000_0000);
        chk("wr4_vld", 32'(vld_w), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
